cand_sampler: RTL and testbench

//  Rejection sampler that sits directly upstream of a single-constraint checker
//  (e.g. the 39-bit var_6 != constant check). It generates pseudo-random

---
 rtl/cand_sampler.sv | 121 ++++++++++++
 tb/tb_cand_sampler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cand_sampler.sv
// Rejection sampler: steps a 64-bit Galois LFSR, presents each candidate to an
// external combinational checker and returns the first passing one (or the last tried).
module cand_sampler #(
  parameter int          WIDTH     = 39,
  parameter logic [63:0] SEED      = 64'h0000_0000_0000_0001,
  parameter int          MAX_TRIES = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [63:0]      seed_in,
  output logic [WIDTH-1:0] cand,
  output logic             cand_valid,
  input  logic             chk_ok,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_value,
  output logic             res_sat,
  output logic [CNT_W-1:0] res_tries
);

  if (WIDTH < 1 || WIDTH > 64 || MAX_TRIES < 1 ||
      MAX_TRIES > (2 ** CNT_W) - 1 || SEED == 64'd0) begin : g_bad_params
    $fatal(1, "cand_sampler: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, GEN, CHECK, DONE} state_t;

  state_t           state, state_nx;
  logic [63:0]      lfsr, lfsr_nx, lfsr_step_val;
  logic [WIDTH-1:0] cand_nx, res_value_nx;
  logic [CNT_W-1:0] tries, tries_nx, res_tries_nx;
  logic             res_sat_nx;

  // Right-shifting Galois step; taps 64,63,61,60 keep the state away from zero.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0000_0000_0000_0000);
  endfunction

  assign lfsr_step_val = lfsr_step(lfsr);
  assign cand_valid    = (state == CHECK);
  assign busy          = (state != IDLE);
  assign res_valid     = (state == DONE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED;
      cand      <= {WIDTH{1'b0}};
      tries     <= {CNT_W{1'b0}};
      res_value <= {WIDTH{1'b0}};
      res_sat   <= 1'b0;
      res_tries <= {CNT_W{1'b0}};
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      cand      <= cand_nx;
      tries     <= tries_nx;
      res_value <= res_value_nx;
      res_sat   <= res_sat_nx;
      res_tries <= res_tries_nx;
    end
  end

  // Next-state and next-datapath logic; every register holds unless its state updates it.
  always_comb begin
    state_nx     = state;
    lfsr_nx      = lfsr;
    cand_nx      = cand;
    tries_nx     = tries;
    res_value_nx = res_value;
    res_sat_nx   = res_sat;
    res_tries_nx = res_tries;
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_nx = (seed_in == 64'd0) ? SEED : seed_in;
        end else begin
          lfsr_nx = lfsr;
        end
        if (start) begin
          tries_nx = {CNT_W{1'b0}};
          state_nx = GEN;
        end else begin
          state_nx = IDLE;
        end
      end
      GEN: begin
        lfsr_nx  = lfsr_step_val;
        cand_nx  = lfsr_step_val[WIDTH-1:0];
        tries_nx = tries + {{(CNT_W-1){1'b0}}, 1'b1};
        state_nx = CHECK;
      end
      CHECK: begin
        if (chk_ok || (tries == CNT_W'(MAX_TRIES))) begin
          res_sat_nx   = chk_ok;
          res_value_nx = cand;
          res_tries_nx = tries;
          state_nx     = DONE;
        end else begin
          state_nx = GEN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cand_sampler.sv
// Directed bench for cand_sampler (MAX_TRIES=4): table of requests plus hand-written
// sequences for reset and mid-operation reset.
module tb_cand_sampler;

  localparam int          W    = 39;
  localparam int          CW   = 16;
  localparam int          MT   = 4;
  localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;

  logic          clk = 1'b0;
  logic          rst_n, start, seed_load, chk_ok, res_ready;
  logic [63:0]   seed_in;
  logic [W-1:0]  cand, res_value;
  logic          cand_valid, busy, res_valid, res_sat;
  logic [CW-1:0] res_tries;

  int n_cmp  = 0;
  int n_fail = 0;
  int pass_on = -1;   // -1: T1 checker (cand != const); 0: never pass; n: pass on nth try
  int pulse_cnt = 0;
  int base = 0;
  logic [63:0] m_lfsr = SEED;

  cand_sampler #(.WIDTH(W), .SEED(SEED), .MAX_TRIES(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .cand(cand), .cand_valid(cand_valid), .chk_ok(chk_ok), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_sat(res_sat), .res_tries(res_tries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cand_valid) pulse_cnt <= pulse_cnt + 1;

  assign chk_ok = cand_valid &&
                  ((pass_on < 0) ? (cand != 39'h27_6a29_11cf)
                                 : ((pass_on != 0) && ((pulse_cnt - base) == (pass_on - 1))));

  function automatic logic [63:0] model_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic [63:0] seed;
    int          pass_on;
    int          k;
    logic        sat;
    int          hold;
    logic        noise;
  } vec_t;

  task automatic run_req(input vec_t v);
    int n;
    logic fin;
    logic [W-1:0] last;
    n = 0; fin = 1'b0; last = '0;
    @(posedge clk); #1;
    if (v.ld) begin
      seed_load = 1'b1;
      seed_in   = v.seed;
      m_lfsr    = (v.seed == 64'd0) ? SEED : v.seed;
    end
    pass_on = v.pass_on;
    base    = pulse_cnt;
    start   = 1'b1;
    while (!fin && n < 60) begin
      @(posedge clk); n++;
      if (n == 1) begin
        #1;
        start     = v.noise;
        seed_load = v.noise;
        seed_in   = 64'h5555_AAAA_5555_AAAA;
      end
      @(negedge clk);
      if (cand_valid) begin
        m_lfsr = model_step(m_lfsr);
        last   = m_lfsr[W-1:0];
        check("cand", 64'(cand), 64'(last));
      end
      if (res_valid) fin = 1'b1;
    end
    start = 1'b0; seed_load = 1'b0;
    check("latency", 64'(n), 64'(2 * v.k + 1));
    check("res_value", 64'(res_value), 64'(last));
    check("res_tries", 64'(res_tries), 64'(v.k));
    check("res_sat", 64'(res_sat), 64'(v.sat));
    for (int i = 0; i < v.hold; i++) begin
      start = 1'b1; seed_load = 1'b1; seed_in = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_value", 64'(res_value), 64'(last));
      check("hold_tries", 64'(res_tries), 64'(v.k));
      check("hold_sat", 64'(res_sat), 64'(v.sat));
    end
    start = 1'b0; seed_load = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(res_valid), 64'd0);
    check("release_busy", 64'(busy), 64'd0);
    res_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int cnt;
    vecs[0] = '{ld: 1'b0, seed: 64'h0, pass_on: -1, k: 1, sat: 1'b1, hold: 0, noise: 1'b0};
    vecs[1] = '{ld: 1'b0, seed: 64'h0, pass_on: 0,  k: 4, sat: 1'b0, hold: 0, noise: 1'b0};
    vecs[2] = '{ld: 1'b0, seed: 64'h0, pass_on: 0,  k: 4, sat: 1'b0, hold: 5, noise: 1'b0};
    vecs[3] = '{ld: 1'b1, seed: 64'h0, pass_on: 1,  k: 1, sat: 1'b1, hold: 0, noise: 1'b0};
    vecs[4] = '{ld: 1'b1, seed: 64'h0123_4567_89AB_CDEF, pass_on: 2, k: 2, sat: 1'b1, hold: 0, noise: 1'b1};
    vecs[5] = '{ld: 1'b1, seed: 64'hFFFF_FFFF_FFFF_FFFF, pass_on: 3, k: 3, sat: 1'b1, hold: 0, noise: 1'b0};
    vecs[6] = '{ld: 1'b0, seed: 64'h0, pass_on: 3,  k: 3, sat: 1'b1, hold: 0, noise: 1'b0};
    vecs[7] = '{ld: 1'b1, seed: 64'h8000_0000_0000_0001, pass_on: 4, k: 4, sat: 1'b1, hold: 0, noise: 1'b0};

    rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed_in = 64'h0; res_ready = 1'b0;
    #12;
    check("rst_cand", 64'(cand), 64'd0);
    check("rst_outs", {59'd0, cand_valid, busy, res_valid, res_sat, 1'b0}, 64'd0);
    check("rst_value", 64'(res_value), 64'd0);
    check("rst_tries", 64'(res_tries), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // T1 first from reset: the very first candidate is zero.
    run_req(vecs[0]);
    check("t1_value_zero", 64'(res_value), 64'd0);
    for (int i = 1; i < 8; i++) run_req(vecs[i]);

    // T6: reset asserted during CHECK of try 2.
    @(posedge clk); #1;
    seed_load = 1'b1; seed_in = 64'h0123_4567_89AB_CDEF; start = 1'b1;
    pass_on = 0; base = pulse_cnt;
    @(posedge clk); #1;
    seed_load = 1'b0; start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      if (cand_valid) cnt++;
    end
    check("t6_reached_try2", 64'(cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t6_cand", 64'(cand), 64'd0);
    check("t6_outs", {59'd0, cand_valid, busy, res_valid, res_sat, 1'b0}, 64'd0);
    check("t6_value", 64'(res_value), 64'd0);
    check("t6_tries", 64'(res_tries), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    m_lfsr = SEED;
    run_req(vecs[0]);
    check("t6_value_zero", 64'(res_value), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
